// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package riscv_fetch_pkg;

    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] PC_INCR          = 32'd4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    // Fetch is word-granular; low address bits are dropped, not trapped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of fetched {instr, pc} entries with single-cycle flush.
module fetch_buffer
    import riscv_fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  fetch_entry_t      i_push_data,
    input  logic              i_pop,
    input  logic              i_flush,
    output logic [CNT_W-1:0]  o_count,
    output fetch_entry_t      o_head
);

    fetch_entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0]       r_rd;
    logic [PTR_W-1:0]       r_wr;
    logic [CNT_W-1:0]       r_count;
    logic                   w_do_pop;
    logic                   w_do_push;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count < CNT_W'(DEPTH)) || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr] <= i_push_data;
                r_wr        <= ptr_next(r_wr);
            end
            if (w_do_pop) r_rd <= ptr_next(r_rd);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd];

endmodule

// File: rtl/fetch_sequencer.sv
// Drives sequential word fetches into a 1-cycle-latency instruction memory and
// hands the returned words to decode over valid/ready, flushing on redirect.
module fetch_sequencer
    import riscv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    logic [XLEN-1:0]  r_req_pc;
    logic             r_inflight;
    logic [XLEN-1:0]  r_inflight_pc;
    fetch_entry_t     r_hold;

    logic [CNT_W-1:0] w_count;
    logic [CNT_W:0]   w_occ;
    fetch_entry_t     w_head;
    fetch_entry_t     w_push_data;
    logic             w_valid;
    logic             w_pop;
    logic             w_push;
    logic             w_issue;

    assign w_valid = (w_count != '0);
    assign w_pop   = w_valid && if_ready;
    assign w_push  = r_inflight && !redirect_valid;

    // Occupancy after this edge if we issue: buffered + in flight - leaving.
    assign w_occ   = {1'b0, w_count} + (CNT_W+1)'(r_inflight) - (CNT_W+1)'(w_pop);
    assign w_issue = !redirect_valid && (w_occ < (CNT_W+1)'(BUF_DEPTH));

    assign w_push_data.instr = imem_rdata;
    assign w_push_data.pc    = r_inflight_pc;

    fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .i_flush     (redirect_valid),
        .o_count     (w_count),
        .o_head      (w_head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_pc      <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (redirect_valid) begin
            r_req_pc      <= align_pc(redirect_pc);
            r_inflight    <= 1'b0;
        end else if (w_issue) begin
            r_req_pc      <= r_req_pc + PC_INCR;
            r_inflight    <= 1'b1;
            r_inflight_pc <= r_req_pc;
        end else begin
            r_inflight    <= 1'b0;
        end
    end

    // Last presented head, so the outputs hold their value while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_hold <= '0;
        else if (w_valid) r_hold <= w_head;
    end

    assign imem_addr = r_req_pc;
    assign if_valid  = w_valid;
    assign if_instr  = w_valid ? w_head.instr : r_hold.instr;
    assign if_pc     = w_valid ? w_head.pc    : r_hold.pc;

endmodule
